req_arbiter: RTL and testbench
==============================

// Module: req_arbiter
// PURPOSE
//  Grants one shared resource to up to N_REQ requesters. Builds on our
//  fixed-priority encoder convention: highest index wins, and the grant is
//  also reported as a binary id.
//  Adds registered grants, grant hold while the winner keeps requesting,
//  a MAX_HOLD anti-starvation preempt, and a runtime round-robin mode.
//  Sits in front of any single-ported datapath block shared by 2..8 agents.
// PARAMETERS
//  N_REQ     4   number of requesters, 2..8
//  MAX_HOLD  8   max consecutive grant cycles while others wait, >=2
//  ID_W      $clog2(N_REQ)   derived, not overridden
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  req        in   N_REQ  level requests; req[i] high = agent i wants resource
//  rr_mode    in   1      0 = fixed priority (index N_REQ-1 highest), 1 = round-robin
//  gnt        out  N_REQ  one-hot grant, registered; all-zero when idle
//  gnt_id     out  ID_W   binary index of the granted agent; valid when gnt_valid=1
//  gnt_valid  out  1      1 = gnt is non-zero; equals |gnt
//  preempt    out  1      1-cycle pulse on the cycle a grant is taken by timeout
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): gnt=0, gnt_id=0, gnt_valid=0, preempt=0,
//   hold_cnt=0, last_id=0, state=IDLE. Reset aborts any held grant at once.
//  FSM states: IDLE, BUSY.
//  IDLE: if |req, go to BUSY. gnt/gnt_id are loaded with the winner on that edge.
//   Latency is 1 clk from req to gnt. hold_cnt=0. Otherwise stay in IDLE with gnt=0.
//  BUSY with owner k:
//   Release: req[k]=0 at an edge.
//    If any other req is high, grant the new winner on the same edge.
//     Back-to-back grants have no idle gap. Reset hold_cnt.
//    Else go to IDLE with gnt=0.
//   Hold: req[k]=1 and hold_cnt<MAX_HOLD-1. Keep the grant and increment hold_cnt.
//   Timeout: req[k]=1, hold_cnt==MAX_HOLD-1 and another req is high.
//    Grant the winner among req & ~(1<<k), pulse preempt for 1 cycle, reset hold_cnt.
//   Timeout with no other requester: keep the grant. hold_cnt saturates at MAX_HOLD-1.
//  Winner selection:
//   Fixed mode: highest set index of the candidate vector.
//   RR mode: the highest index in the descending circular order starting at
//    (last_id-1) mod N_REQ. last_id updates on every new grant, in both modes.
//   Reset last_id=0, so the first RR pick equals the fixed-mode pick.
//  rr_mode is sampled only at the arbitration edge. It never revokes a held grant.
//  Invariants:
//   gnt is always one-hot or zero.
//   gnt_id == index of the set bit.
//   Only the owner's req is examined for hold.
//   Requests that are not granted are never latched. Dropping req before the
//    grant cancels the request.
// STRUCTURE
//  Package arb_pkg:
//   typedef enum logic {IDLE, BUSY} arb_state_t
//   function onehot(id)
//   localparam MAX_N_REQ=8
//  Sub-module prio_pick:
//   Combinational fixed-priority encoder, N inputs -> id + valid.
//   Highest index wins.
//  RR mode rotates the candidates by last_id, feeds prio_pick, then
//   un-rotates the resulting id.
//  Top level holds the FSM, hold_cnt, last_id and the output registers.
// TESTING  (N_REQ=4, MAX_HOLD=8)
//  Reset:
//   rst_n=0 for 2 clk with req=4'b1111.
//   -> gnt=0, gnt_valid=0, gnt_id=0, preempt=0 throughout.
//  Fixed priority:
//   rr_mode=0, req 4'b0000->4'b0101.
//   -> next edge gnt=4'b0100, gnt_id=2.
//   Drop req[2] -> next edge gnt=4'b0001, gnt_id=0, no idle cycle.
//  Round-robin:
//   rr_mode=1, hold req=4'b1111 and pulse each owner's req low for 1 clk to release.
//   -> grant order 3,2,1,0,3.
//  Timeout:
//   rr_mode=0, req=4'b1001 held.
//   -> gnt=4'b1000 for exactly 8 cycles.
//   -> then gnt=4'b0001 with preempt=1 for 1 cycle.
//  Lone hold:
//   req=4'b0010 held for 20 clk.
//   -> gnt=4'b0010 for all 20 cycles, preempt never asserts.
//  Reset mid-grant:
//   While gnt=4'b1000, assert rst_n=0 for 1 clk.
//   -> gnt=0 on that edge. The first grant after reset follows the reset last_id.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type, limits and one-hot helper for req_arbiter
package arb_pkg;
    localparam int MAX_N_REQ = 8;
    localparam int MAX_ID_W  = $clog2(MAX_N_REQ);
    typedef enum logic {IDLE, BUSY} arb_state_t;
    function automatic logic [MAX_N_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] id);
        return MAX_N_REQ'(1) << id;
    endfunction
endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational fixed-priority encoder, highest set index wins
//   vec   in   N     candidate vector
//   id    out  ID_W  index of the highest set bit (0 when vec is zero)
//   valid out  1     vec is non-zero
module prio_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    output logic [ID_W-1:0] id,
    output logic            valid
);
    always_comb begin
        id = '0;
        for (int i = 0; i < N; i++) id = vec[i] ? ID_W'(i) : id;
    end
    assign valid = |vec;
endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: registered fixed-priority / round-robin arbiter with grant hold and timeout preempt
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous reset, active low
//   req       in   N_REQ  level requests
//   rr_mode   in   1      0 = fixed priority (highest index), 1 = round-robin
//   gnt       out  N_REQ  registered one-hot grant, zero when idle
//   gnt_id    out  ID_W   binary index of the granted agent
//   gnt_valid out  1      |gnt
//   preempt   out  1      one-cycle pulse when a grant is taken by timeout
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             preempt
);
    localparam int HC_W = $clog2(MAX_HOLD);
    arb_state_t       state, state_d;
    logic [HC_W-1:0]  hold_cnt, hold_d;
    logic [ID_W-1:0]  last_id, last_d, gnt_id_d, rot_id, pick_id;
    logic [N_REQ-1:0] cand, rot, gnt_d;
    logic             pick_v, preempt_d, owner_req, timeout, arb, grant_new;
    int               sh;
    // The owner's bit is excluded so a timeout hands over; on release it is already 0.
    // RR rotates so that (last_id-1) lands on the top index, which prio_pick favours.
    always_comb begin
        sh   = rr_mode ? int'(last_id) : 0;
        cand = req & ~gnt;
        rot  = '0;
        for (int j = 0; j < N_REQ; j++) rot[j] = cand[ID_W'((j + sh) % N_REQ)];
        pick_id = ID_W'((int'(rot_id) + sh) % N_REQ);
    end
    prio_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
        .vec   (rot),
        .id    (rot_id),
        .valid (pick_v)
    );
    always_comb begin
        owner_req = state == BUSY && req[gnt_id];
        timeout   = owner_req && hold_cnt == HC_W'(MAX_HOLD - 1);
        arb       = !owner_req || (timeout && |cand);
        grant_new = arb && pick_v;
        state_d   = arb && !pick_v ? IDLE : BUSY;
        gnt_d     = grant_new ? N_REQ'(onehot(MAX_ID_W'(pick_id))) : (arb ? '0 : gnt);
        gnt_id_d  = grant_new ? pick_id : (arb ? '0 : gnt_id);
        last_d    = grant_new ? pick_id : last_id;
        hold_d    = arb ? '0 : (timeout ? hold_cnt : hold_cnt + 1'b1);
        preempt_d = grant_new && owner_req;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            last_id  <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            gnt_id   <= gnt_id_d;
            last_id  <= last_d;
            hold_cnt <= hold_d;
            preempt  <= preempt_d;
        end
    end
    assign gnt_valid = |gnt;
endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: scoreboard bench for req_arbiter (N_REQ=4, MAX_HOLD=8)
module tb_req_arbiter;
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       pre;
        logic       chk_id;
    } exp_t;
    logic       clk, rst_n, rr_mode, gnt_valid, preempt;
    logic [3:0] req, gnt;
    logic [1:0] gnt_id;
    exp_t       exp_q[$];
    string      name_q[$];
    int         checks, errors;
    req_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step(input logic r, input logic [3:0] rq, input logic m,
                        input logic [3:0] eg, input logic [1:0] ei, input logic ep,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst_n   = r;
        req     = rq;
        rr_mode = m;
        e.gnt    = eg;
        e.id     = ei;
        e.pre    = ep;
        e.chk_id = !r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || preempt !== e.pre ||
                    ((e.chk_id || (|e.gnt)) && gnt_id !== e.id)) begin
                    errors++;
                    $display("FAIL %s: got gnt=%b id=%0d valid=%b preempt=%b, expected gnt=%b id=%0d valid=%b preempt=%b",
                             nm, gnt, gnt_id, gnt_valid, preempt, e.gnt, e.id, |e.gnt, e.pre);
                end
            end
        end
    end
    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        rr_mode = 1'b0;
        step(0, 4'b1111, 0, 4'b0000, 2'd0, 0, "reset_1");
        step(0, 4'b1111, 0, 4'b0000, 2'd0, 0, "reset_2");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "idle");
        step(1, 4'b0101, 0, 4'b0100, 2'd2, 0, "fixed_pick");
        step(1, 4'b0101, 0, 4'b0100, 2'd2, 0, "fixed_hold");
        step(1, 4'b0001, 0, 4'b0001, 2'd0, 0, "fixed_handover");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "fixed_release");
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "rr_prereset");
        step(1, 4'b1111, 1, 4'b1000, 2'd3, 0, "rr_first");
        step(1, 4'b0111, 1, 4'b0100, 2'd2, 0, "rr_to_2");
        step(1, 4'b1111, 1, 4'b0100, 2'd2, 0, "rr_hold_2");
        step(1, 4'b1011, 1, 4'b0010, 2'd1, 0, "rr_to_1");
        step(1, 4'b1111, 1, 4'b0010, 2'd1, 0, "rr_hold_1");
        step(1, 4'b1101, 1, 4'b0001, 2'd0, 0, "rr_to_0");
        step(1, 4'b1111, 1, 4'b0001, 2'd0, 0, "rr_hold_0");
        step(1, 4'b1110, 1, 4'b1000, 2'd3, 0, "rr_wrap_3");
        step(1, 4'b0000, 1, 4'b0000, 2'd0, 0, "rr_release");
        for (int i = 0; i < 8; i++) step(1, 4'b1001, 0, 4'b1000, 2'd3, 0, "timeout_hold");
        step(1, 4'b1001, 0, 4'b0001, 2'd0, 1, "timeout_preempt");
        step(1, 4'b1001, 0, 4'b0001, 2'd0, 0, "timeout_after");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "timeout_release");
        for (int i = 0; i < 20; i++) step(1, 4'b0010, 0, 4'b0010, 2'd1, 0, "lone_hold");
        step(1, 4'b1000, 0, 4'b1000, 2'd3, 0, "mid_grant");
        step(0, 4'b1000, 0, 4'b0000, 2'd0, 0, "mid_reset");
        step(1, 4'b1111, 1, 4'b1000, 2'd3, 0, "post_reset_rr");
        step(1, 4'b0000, 1, 4'b0000, 2'd0, 0, "final_idle");
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
